// File: rtl/sram_access_sequencer.sv
// Chip-enable / output-enable / write-enable sequencer for four 64 KB SRAM blocks,
// with a programmable wait-state count and DtAck generation back to the 68k.
module sram_access_sequencer #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       Clock,
  input  logic       Reset_H,
  input  logic       AS_L,
  input  logic       RW,
  input  logic       UDS_L,
  input  logic       LDS_L,
  input  logic       SRamSelect_H,
  input  logic [3:0] Block_H,
  output logic [3:0] SRam_CE_L,
  output logic       SRam_OE_L,
  output logic       SRam_WE_L,
  output logic       SRam_UB_L,
  output logic       SRam_LB_L,
  output logic       DtAck_L,
  output logic       Busy_H
);

  localparam int unsigned NBLK = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ACK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [NBLK-1:0]  blk_q, blk_nxt;
  logic             rw_q, rw_nxt;
  logic [NBLK-1:0]  ce_nxt;
  logic             oe_nxt, we_nxt, dtack_nxt, busy_nxt;
  logic             start, strobe, count_en, one_hot;

  assign strobe  = ~UDS_L | ~LDS_L;
  assign one_hot = (Block_H != '0) && ((Block_H & (Block_H - NBLK'(1))) == '0);
  assign start   = ~AS_L & SRamSelect_H & one_hot;
  // Writes only burn wait states once the 68k has driven data for a full cycle.
  assign count_en = rw_q | ~SRam_WE_L;

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    blk_nxt   = blk_q;
    rw_nxt    = rw_q;
    ce_nxt    = '1;
    oe_nxt    = 1'b1;
    we_nxt    = 1'b1;
    dtack_nxt = 1'b1;
    busy_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          blk_nxt   = Block_H;
          rw_nxt    = RW;
        end
      end
      SETUP: begin
        if (AS_L) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = CNT_W'(WAIT_STATES);
          state_nxt = (WAIT_STATES == 0) ? ACK : ACCESS;
        end
      end
      ACCESS: begin
        if (AS_L) begin
          state_nxt = IDLE;
        end else if (count_en) begin
          if (cnt == CNT_W'(1)) state_nxt = ACK;
          else                  cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      ACK: begin
        if (AS_L) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != IDLE) begin
      busy_nxt = 1'b1;
      ce_nxt   = ~blk_nxt;
      oe_nxt   = ~rw_nxt;
    end
    if (state_nxt == ACCESS && !rw_nxt && strobe) we_nxt = 1'b0;
    if (state_nxt == ACK) dtack_nxt = 1'b0;
  end

  // State, latched request and registered SRAM/bus outputs.
  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      state     <= IDLE;
      cnt       <= '0;
      blk_q     <= '0;
      rw_q      <= 1'b0;
      SRam_CE_L <= '1;
      SRam_OE_L <= 1'b1;
      SRam_WE_L <= 1'b1;
      DtAck_L   <= 1'b1;
      Busy_H    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      blk_q     <= blk_nxt;
      rw_q      <= rw_nxt;
      SRam_CE_L <= ce_nxt;
      SRam_OE_L <= oe_nxt;
      SRam_WE_L <= we_nxt;
      DtAck_L   <= dtack_nxt;
      Busy_H    <= busy_nxt;
    end
  end

  assign SRam_UB_L = Busy_H ? UDS_L : 1'b1;
  assign SRam_LB_L = Busy_H ? LDS_L : 1'b1;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Bench for sram_access_sequencer: vector tables, hand-written corner sequences and
// random traffic checked against a transaction-level reference model.
module tb_sram_access_sequencer;

  logic       Clock = 1'b0;
  logic       Reset_H = 1'b1;
  logic       as_l = 1'b1, rw = 1'b1, uds = 1'b1, lds = 1'b1, sel = 1'b0;
  logic [3:0] blk = 4'b0000;

  logic [3:0] ce2, ce0;
  logic       oe2, we2, ub2, lb2, dt2, busy2;
  logic       oe0, we0, ub0, lb0, dt0, busy0;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  sram_access_sequencer #(.WAIT_STATES(2), .CNT_W(4)) u_ws2 (
    .Clock(Clock), .Reset_H(Reset_H), .AS_L(as_l), .RW(rw), .UDS_L(uds), .LDS_L(lds),
    .SRamSelect_H(sel), .Block_H(blk), .SRam_CE_L(ce2), .SRam_OE_L(oe2), .SRam_WE_L(we2),
    .SRam_UB_L(ub2), .SRam_LB_L(lb2), .DtAck_L(dt2), .Busy_H(busy2));

  sram_access_sequencer #(.WAIT_STATES(0), .CNT_W(4)) u_ws0 (
    .Clock(Clock), .Reset_H(Reset_H), .AS_L(as_l), .RW(rw), .UDS_L(uds), .LDS_L(lds),
    .SRamSelect_H(sel), .Block_H(blk), .SRam_CE_L(ce0), .SRam_OE_L(oe0), .SRam_WE_L(we0),
    .SRam_UB_L(ub0), .SRam_LB_L(lb0), .DtAck_L(dt0), .Busy_H(busy0));

  // Access-level view: is a cycle open, still in its setup cycle, acknowledged yet,
  // how many wait states have been served, and was write data presented last cycle.
  typedef struct {
    bit         active;
    bit         setup;
    bit         acked;
    bit         rw;
    logic [3:0] blk;
    int         credits;
    bit         we_low;
  } mdl_t;

  mdl_t m2, m0;

  function automatic mdl_t idle_model();
    mdl_t n;
    n.active = 0; n.setup = 0; n.acked = 0; n.rw = 0;
    n.blk = 4'b0000; n.credits = 0; n.we_low = 0;
    return n;
  endfunction

  function automatic mdl_t step(mdl_t m, int ws, logic a_l, logic r, logic u, logic l,
                                logic s, logic [3:0] b);
    mdl_t n;
    bit   data_on;
    n = m;
    data_on = !u || !l;
    if (!m.active) begin
      if (!a_l && s && $countones(b) == 1) begin
        n.active = 1; n.setup = 1; n.acked = 0; n.rw = r; n.blk = b; n.credits = 0;
      end
    end else if (a_l) begin
      n = idle_model();
    end else if (m.setup) begin
      n.setup = 0;
      n.acked = (ws == 0);
    end else if (!m.acked) begin
      if (m.rw || m.we_low) n.credits = m.credits + 1;
      if (n.credits == ws) n.acked = 1;
    end
    n.we_low = n.active && !n.setup && !n.acked && !n.rw && data_on;
    return n;
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_model(input string tag, input mdl_t m, input logic [3:0] ce,
                             input logic oe, input logic we, input logic dt,
                             input logic busy, input logic ub, input logic lb);
    cmp({tag, "_ce"},   ce,   m.active ? ~m.blk : 4'b1111);
    cmp({tag, "_oe"},   oe,   !(m.active && m.rw));
    cmp({tag, "_we"},   we,   !m.we_low);
    cmp({tag, "_dt"},   dt,   !(m.active && m.acked));
    cmp({tag, "_busy"}, busy, m.active);
    cmp({tag, "_ub"},   ub,   m.active ? uds : 1'b1);
    cmp({tag, "_lb"},   lb,   m.active ? lds : 1'b1);
    cmp({tag, "_ce_max1"}, 4'($countones(~ce) <= 1), 4'd1);
    cmp({tag, "_oe_we_excl"}, 4'(!oe && !we), 4'd0);
  endtask

  // One rising edge: advance both models with the sampled inputs, then compare.
  task automatic tick();
    @(posedge Clock);
    if (Reset_H) begin
      m2 = idle_model();
      m0 = idle_model();
    end else begin
      m2 = step(m2, 2, as_l, rw, uds, lds, sel, blk);
      m0 = step(m0, 0, as_l, rw, uds, lds, sel, blk);
    end
    #1;
    check_model("ws2", m2, ce2, oe2, we2, dt2, busy2, ub2, lb2);
    check_model("ws0", m0, ce0, oe0, we0, dt0, busy0, ub0, lb0);
  endtask

  task automatic drive(input logic a_l, input logic r, input logic u, input logic l,
                       input logic s, input logic [3:0] b);
    as_l = a_l; rw = r; uds = u; lds = l; sel = s; blk = b;
  endtask

  task automatic expect_idle2(input string tag);
    cmp({tag, "_ce"}, ce2, 4'b1111);
    cmp({tag, "_busy"}, busy2, 1'b0);
    cmp({tag, "_dt"}, dt2, 1'b1);
    cmp({tag, "_oe"}, oe2, 1'b1);
    cmp({tag, "_we"}, we2, 1'b1);
  endtask

  typedef struct {
    logic       as_l, rw, uds, lds, sel;
    logic [3:0] blk;
    logic [3:0] ce;
    logic       oe, we, dt, busy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    m2 = idle_model();
    m0 = idle_model();
    // Rows 0-6: WS=2 read of block 2 (Block_H/RW/select wiggle after start).
    // Rows 7-14: WS=2 write of block 0 with LDS_L arriving late.
    tbl = '{
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0}
    };

    // Reset state.
    repeat (2) tick();
    expect_idle2("reset");
    cmp("reset_ub", ub2, 1'b1);
    Reset_H = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    tick();

    // Table-driven cycle sequences.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].as_l, tbl[i].rw, tbl[i].uds, tbl[i].lds, tbl[i].sel, tbl[i].blk);
      tick();
      cmp($sformatf("vec%0d_ce", i), ce2, tbl[i].ce);
      cmp($sformatf("vec%0d_oe", i), oe2, tbl[i].oe);
      cmp($sformatf("vec%0d_we", i), we2, tbl[i].we);
      cmp($sformatf("vec%0d_dt", i), dt2, tbl[i].dt);
      cmp($sformatf("vec%0d_busy", i), busy2, tbl[i].busy);
      cmp($sformatf("vec%0d_ub", i), ub2, tbl[i].busy ? tbl[i].uds : 1'b1);
      cmp($sformatf("vec%0d_lb", i), lb2, tbl[i].busy ? tbl[i].lds : 1'b1);
    end

    // Asynchronous reset in the middle of an ACCESS read.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010);
    tick();
    tick();
    cmp("pre_rst_busy", busy2, 1'b1);
    #3 Reset_H = 1'b1;
    #1;
    expect_idle2("async_rst");
    cmp("async_rst_ub", ub2, 1'b1);
    cmp("async_rst_lb", lb2, 1'b1);
    tick();
    Reset_H = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010);
    tick();
    cmp("post_rst_ce", ce2, 4'b1101);
    tick();
    tick();
    cmp("post_rst_dt_early", dt2, 1'b1);
    tick();
    cmp("post_rst_dt", dt2, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    expect_idle2("post_rst_end");

    // Zero wait states, read on block 3.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000);
    tick();
    cmp("ws0_ce", ce0, 4'b0111);
    cmp("ws0_dt_setup", dt0, 1'b1);
    tick();
    cmp("ws0_dt", dt0, 1'b0);
    cmp("ws0_oe", oe0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    cmp("ws0_release", ce0, 4'b1111);
    tick();

    // Abort during ACCESS.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001);
    tick();
    tick();
    cmp("abort_dt_access", dt2, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001);
    tick();
    expect_idle2("abort");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    tick();

    // Bad block selects never start a cycle.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    tick();
    expect_idle2("bad_zero");
    cmp("bad_zero_ws0_busy", busy0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
    tick();
    expect_idle2("bad_multi");
    cmp("bad_multi_ws0_ce", ce0, 4'b1111);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    tick();

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      int unsigned r;
      logic [3:0]  b;
      r = $urandom_range(0, 7);
      case (r)
        0, 1, 2, 3: begin b = 4'b0001; b = b << r; end
        4:          b = 4'b0000;
        5:          b = 4'b0110;
        default:    b = 4'($urandom);
      endcase
      drive(($urandom_range(0, 5) == 0), 1'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) != 0), b);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_access_sequencer.md
Name: sram_access_sequencer

Overview:
- Sits directly downstream of the SRAM block decoder; consumes its four one-hot block selects plus the 68k bus strobes.
- Generates registered chip-enable, output-enable and write-enable timing for the four 64 KB SRAM blocks, and returns DtAck_L to the 68k.
- Inserts a programmable number of wait states.
- All 68k inputs are synchronous to Clock; the block contains no synchronizers.

Parameters:
- WAIT_STATES, 2: number of ACCESS cycles before acknowledge (legal range 0-15).
- CNT_W, 4: width of the wait counter.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset_H  in  1  asynchronous, active-high reset.
- AS_L  in  1  68k address strobe.
- RW  in  1  68k read/write: 1 = read, 0 = write.
- UDS_L  in  1  upper data strobe.
- LDS_L  in  1  lower data strobe.
- SRamSelect_H  in  1  top-level decode: SRAM space addressed.
- Block_H  in  4  one-hot block selects from the block decoder; bit n = block n.
- SRam_CE_L  out  4  per-block chip enable, active low.
- SRam_OE_L  out  1  output enable, active low.
- SRam_WE_L  out  1  write enable, active low.
- SRam_UB_L  out  1  upper byte lane enable.
- SRam_LB_L  out  1  lower byte lane enable.
- DtAck_L  out  1  data acknowledge to 68k.
- Busy_H  out  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - Reset_H=1 forces state IDLE and clears the counter and latched block/RW.
  - All active-low outputs go to 1; Busy_H goes to 0. Effect is immediate (asynchronous) and also applies mid-cycle.
- Outputs: SRam_CE_L, SRam_OE_L, SRam_WE_L, DtAck_L and Busy_H are registered (state-decoded from flops). SRam_UB_L and SRam_LB_L equal UDS_L and LDS_L when Busy_H=1; otherwise they are 1.
- IDLE:
  - All outputs are inactive.
  - Start condition, sampled at an edge: AS_L=0, SRamSelect_H=1 and Block_H has exactly one bit set.
  - On start: latch Block_H and RW, go to SETUP.
  - Block_H of zero or multi-hot means no start; stay in IDLE.
- SETUP (1 cycle):
  - CE_L is low for the latched block only.
  - OE_L is low if the latched RW=1.
  - WE_L stays 1.
  - Next edge: load counter = WAIT_STATES; go to ACCESS, or directly to ACK if WAIT_STATES=0.
- ACCESS:
  - CE and OE are held as in SETUP.
  - Read: counter decrements each cycle.
  - Write: WE_L is low only while UDS_L=0 or LDS_L=0. The counter decrements only in cycles where a data strobe is low, so the cycle stalls until the 68k presents data.
  - At the edge where the counter is 1 and would decrement, go to ACK.
- ACK:
  - DtAck_L=0. CE is held.
  - Read: OE is held.
  - Write: WE_L returns to 1 (data hold); CE is held.
  - Remain in ACK while AS_L=0. At the first edge with AS_L=1, go to IDLE; all outputs release on that edge.
- Abort: AS_L=1 sampled in SETUP or ACCESS goes to IDLE at that edge with no DtAck.
- Input stability: changes on Block_H or RW after the start edge are ignored; the latched values are used.
- Latency (read, no stall): DtAck_L is low starting WAIT_STATES+1 edges after the start edge.
  - WAIT_STATES=2: start edge 0, DtAck low from edge 3.
- Back-to-back cycles: the earliest new start is the edge after the return to IDLE. At least one idle cycle occurs between accesses.
- Invariants: at most one CE_L bit is low at any time. OE_L and WE_L are never both 0.

Test Plan:
- Reset: hold Reset_H=1 during an active read in ACCESS -> all outputs 1 and Busy_H=0 immediately; after release, a fresh read completes normally.
- Read, WAIT_STATES=2, Block_H=4'b0100, RW=1, strobes low at edge 0:
  - From edge 1: CE_L=4'b1011, OE_L=0.
  - DtAck_L=0 from edge 3.
  - AS_L=1 at edge 5 -> all outputs 1 after edge 5.
- Write with delayed strobes: Block_H=4'b0001, RW=0, UDS_L=LDS_L=1 until edge 4 then LDS_L=0 -> WE_L=0 only from edge 4; DtAck at edge 6; UB_L=1, LB_L=0.
- WAIT_STATES=0 read on block 3 -> CE_L=4'b0111 after edge 0; DtAck_L=0 after edge 1.
- Abort: AS_L rises in ACCESS -> return to IDLE on that edge; DtAck_L never asserted.
- Bad select: SRamSelect_H=1 with Block_H=4'b0000, then with 4'b0110 -> state stays IDLE; no CE asserted; Busy_H=0.
